// File: rtl/phase_downcounter_pkg.sv
// Shared phase encoding and length-clamp rule for the CRTC axis sequencer.
// Holds the crtc_defs content (phase codes, minimum length) as a package.
package phase_downcounter_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    // A programmed length below this is raised to it, so no phase is ever skipped.
    localparam int LEN_MIN = 1;

    function automatic phase_t next_phase(input phase_t ph);
        return phase_t'(ph + 2'd1);
    endfunction

endpackage

// File: rtl/phase_downcounter_if.sv
// Timing-config and status bundle between a CRTC axis sequencer and its controller.
interface phase_downcounter_if #(parameter int WIDTH = 12);
    logic             enable;
    logic [WIDTH-1:0] active_len;
    logic [WIDTH-1:0] fp_len;
    logic [WIDTH-1:0] sync_len;
    logic [WIDTH-1:0] bp_len;
    logic             sync_pol;
    logic [WIDTH-1:0] count;
    logic [1:0]       phase;
    logic             display_en;
    logic             sync;
    logic             line_end;

    modport master (
        output enable, active_len, fp_len, sync_len, bp_len, sync_pol,
        input  count, phase, display_en, sync, line_end
    );

    modport slave (
        input  enable, active_len, fp_len, sync_len, bp_len, sync_pol,
        output count, phase, display_en, sync, line_end
    );
endinterface

// File: rtl/phase_downcounter_len_sel.sv
// phase_len_sel: picks the length for the phase being entered and returns
// the counter load value (length - 1), with zero lengths clamped to one tick.
module phase_len_sel
    import phase_downcounter_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  phase_t           sel,
    input  logic [WIDTH-1:0] active_len,
    input  logic [WIDTH-1:0] fp_len,
    input  logic [WIDTH-1:0] sync_len,
    input  logic [WIDTH-1:0] bp_len,
    output logic [WIDTH-1:0] load_val
);

    logic [WIDTH-1:0] len;

    always_comb begin
        len = '0;
        unique case (sel)
            PH_ACTIVE: len = active_len;
            PH_FP:     len = fp_len;
            PH_SYNC:   len = sync_len;
            PH_BP:     len = bp_len;
            default:   len = '0;
        endcase
    end

    assign load_val = (len < WIDTH'(LEN_MIN)) ? '0 : len - WIDTH'(LEN_MIN);

endmodule

// File: rtl/phase_downcounter.sv
// Down-counting ACTIVE/FP/SYNC/BP sequencer for one CRTC axis.
// Optional macro PHASE_DOWNCOUNTER_SHADOW_EN: latch all lengths once per line.
module phase_downcounter
    import phase_downcounter_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int DECREMENT = 1
) (
    input logic                clk,
    input logic                reset_n,
    phase_downcounter_if.slave bus
);

    phase_t           phase_reg;
    phase_t           phase_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] load_val;
    logic             display_en_reg;
    logic             sync_reg;
    logic             line_end_reg;
    logic             expire;
    logic             line_wrap;
    logic [WIDTH-1:0] raw_len [4];
    logic [WIDTH-1:0] src_len [4];

    assign expire     = (count_reg == '0);
    assign line_wrap  = bus.enable && expire && (phase_reg == PH_BP);
    assign phase_next = expire ? next_phase(phase_reg) : phase_reg;
    assign count_dec  = (count_reg < WIDTH'(DECREMENT)) ? '0 : count_reg - WIDTH'(DECREMENT);

    assign raw_len[0] = bus.active_len;
    assign raw_len[1] = bus.fp_len;
    assign raw_len[2] = bus.sync_len;
    assign raw_len[3] = bus.bp_len;

`ifdef PHASE_DOWNCOUNTER_SHADOW_EN
    logic [WIDTH-1:0] shadow_reg [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) shadow_reg[i] <= '0;
        end else if (line_wrap) begin
            for (int i = 0; i < 4; i++) shadow_reg[i] <= raw_len[i];
        end
    end

    // The only load made from BP is the ACTIVE load of a new line; it must see the
    // same values the shadow captures on that edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign src_len[gi] = (phase_reg == PH_BP) ? raw_len[gi] : shadow_reg[gi];
    end
`else
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        assign src_len[gi] = raw_len[gi];
    end
`endif

    phase_len_sel #(.WIDTH(WIDTH)) u_len_sel (
        .sel        (phase_next),
        .active_len (src_len[0]),
        .fp_len     (src_len[1]),
        .sync_len   (src_len[2]),
        .bp_len     (src_len[3]),
        .load_val   (load_val)
    );

    // Reset parks in BP with count 0 so the first enabled tick starts a fresh line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_reg      <= PH_BP;
            count_reg      <= '0;
            display_en_reg <= 1'b0;
            sync_reg       <= ~bus.sync_pol;
            line_end_reg   <= 1'b0;
        end else begin
            line_end_reg <= 1'b0;
            if (bus.enable) begin
                phase_reg      <= phase_next;
                count_reg      <= expire ? load_val : count_dec;
                display_en_reg <= (phase_next == PH_ACTIVE);
                sync_reg       <= (phase_next == PH_SYNC) ^ ~bus.sync_pol;
                line_end_reg   <= line_wrap;
            end
        end
    end

    assign bus.count      = count_reg;
    assign bus.phase      = phase_reg;
    assign bus.display_en = display_en_reg;
    assign bus.sync       = sync_reg;
    assign bus.line_end   = line_end_reg;

endmodule

// File: tb/tb_phase_downcounter.sv
// Directed bench for phase_downcounter: timing tables, stretch, zero lengths,
// mid-line length changes, async reset and inverted sync polarity.
module tb_phase_downcounter;

    localparam int W = 12;

`ifdef PHASE_DOWNCOUNTER_SHADOW_EN
    localparam int FP_AFTER_CHANGE = 1;
    localparam int TAIL_TICKS      = 5;
`else
    localparam int FP_AFTER_CHANGE = 4;
    localparam int TAIL_TICKS      = 8;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pol = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   tbl_ph [16];
    int   tbl_ct [16];
    int   tbl_len = 10;

    phase_downcounter_if #(.WIDTH(W)) bus ();

    phase_downcounter #(.WIDTH(W), .DECREMENT(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input int ph, input int ct, input logic le);
        logic exp_sync;
        exp_sync = (ph == 2) ^ ~pol;
        chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
        chk({tag, ".count"}, 32'(bus.count), 32'(ct));
        chk({tag, ".display_en"}, 32'(bus.display_en), 32'(ph == 0));
        chk({tag, ".sync"}, 32'(bus.sync), 32'(exp_sync));
        chk({tag, ".line_end"}, 32'(bus.line_end), 32'(le));
        $display("%s: phase=%0d count=%0d de=%0b sync=%0b line_end=%0b", tag,
                 bus.phase, bus.count, bus.display_en, bus.sync, bus.line_end);
    endtask

    task automatic do_clk(input logic en);
        bus.enable = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_tbl(input string tag, input int n, input int start, input bit gap);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (start + k) % tbl_len;
            do_clk(1'b1);
            check_state($sformatf("%s[%0d]", tag, k), tbl_ph[idx], tbl_ct[idx], idx == 0);
            if (gap) begin
                do_clk(1'b0);
                check_state($sformatf("%s[%0d].hold", tag, k), tbl_ph[idx], tbl_ct[idx], 1'b0);
            end
        end
    endtask

    task automatic load_std();
        int ph [10] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3};
        int ct [10] = '{3, 2, 1, 0, 1, 0, 2, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            tbl_ph[i] = ph[i];
            tbl_ct[i] = ct[i];
        end
        tbl_len = 10;
    endtask

    task automatic set_lens(input int a, input int f, input int s, input int b);
        bus.active_len = W'(a);
        bus.fp_len     = W'(f);
        bus.sync_len   = W'(s);
        bus.bp_len     = W'(b);
    endtask

    initial begin
        int found;
        bus.enable   = 1'b1;
        bus.sync_pol = 1'b1;
        set_lens(4, 2, 3, 1);
        load_std();

        // Reset held across edges with enable high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", 3, 0, 1'b0);
        reset_n = 1'b1;

        // Continuous enable: two full lines of period 10
        run_tbl("cont", 20, 0, 1'b0);

        // Enable every other clock: same sequence, line_end one clk wide
        run_tbl("stretch", 10, 0, 1'b1);

        // Zero-length FP and SYNC still last one tick each
        set_lens(4, 0, 0, 1);
        begin
            int ph [7] = '{0, 0, 0, 0, 1, 2, 3};
            int ct [7] = '{3, 2, 1, 0, 0, 0, 0};
            for (int i = 0; i < 7; i++) begin
                tbl_ph[i] = ph[i];
                tbl_ct[i] = ct[i];
            end
            tbl_len = 7;
        end
        run_tbl("zero", 14, 0, 1'b0);

        // active_len 4 -> 8 during SYNC takes effect on the next line
        set_lens(4, 2, 3, 1);
        load_std();
        run_tbl("pre", 7, 0, 1'b0);
        bus.active_len = W'(8);
        run_tbl("sync_chg", 3, 7, 1'b0);
        do_clk(1'b1);
        check_state("act8.entry", 0, 7, 1'b1);
        repeat (7) do_clk(1'b1);
        check_state("act8.last", 0, 0, 1'b0);
        do_clk(1'b1);
        check_state("act8.fp", 1, 1, 1'b0);
        repeat (5) do_clk(1'b1);
        check_state("act8.bp", 3, 0, 1'b0);
        do_clk(1'b1);
        check_state("act8b.entry", 0, 7, 1'b1);

        // Mid-ACTIVE changes leave the current ACTIVE alone
        repeat (2) do_clk(1'b1);
        bus.active_len = W'(4);
        bus.fp_len     = W'(5);
        repeat (5) do_clk(1'b1);
        check_state("midact.last", 0, 0, 1'b0);
        do_clk(1'b1);
        check_state("midact.fp", 1, FP_AFTER_CHANGE, 1'b0);
        repeat (TAIL_TICKS) do_clk(1'b1);
        check_state("midact.bp", 3, 0, 1'b0);
        do_clk(1'b1);
        check_state("act4.entry", 0, 3, 1'b1);
        bus.fp_len = W'(2);

        // Async reset in the middle of SYNC
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            do_clk(1'b1);
            if (bus.phase == 2'd2) found = 1;
        end
        chk("reach_sync", 32'(found), 32'd1);
        do_clk(1'b1);
        check_state("in_sync", 2, 1, 1'b0);
        #2 reset_n = 1'b0;
        #1 check_state("async_rst", 3, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_state("rst_hold", 3, 0, 1'b0);
        reset_n = 1'b1;
        do_clk(1'b1);
        check_state("rst_exit", 0, 3, 1'b1);

        // Active-low sync: high during reset and outside SYNC
        reset_n      = 1'b0;
        pol          = 1'b0;
        bus.sync_pol = 1'b0;
        #1 check_state("rst_pol0", 3, 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_tbl("pol0", 20, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_downcounter.md
Name: phase_downcounter

Overview:
- Down-counting timing sequencer for one CRTC axis (horizontal or vertical).
- Loads a programmable duration per phase (ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH), counts it down to zero, then advances to the next phase.
- Emits registered display-enable, sync and end-of-line strobes.
- One instance runs on the pixel/character tick for horizontal timing; a second runs on the first instance's line_end for vertical timing.

Parameters:
- WIDTH, 12: width of the length inputs and of count.
- DECREMENT, 1: amount subtracted per enabled tick. Must be 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  count-enable tick; state advances only when high.
- active_len  input  WIDTH  ACTIVE phase length in ticks.
- fp_len  input  WIDTH  FRONT_PORCH phase length.
- sync_len  input  WIDTH  SYNC phase length.
- bp_len  input  WIDTH  BACK_PORCH phase length.
- sync_pol  input  1  1 = sync active-high, 0 = active-low.
- count  output  WIDTH  ticks remaining in the current phase, minus one.
- phase  output  2  0=ACTIVE, 1=FRONT_PORCH, 2=SYNC, 3=BACK_PORCH.
- display_en  output  1  high while phase==ACTIVE.
- sync  output  1  sync output, polarity set by sync_pol.
- line_end  output  1  one-clk pulse when BACK_PORCH expires.

Behaviour:
- Reset (async, reset_n low):
  - phase=BACK_PORCH, count=0, display_en=0, line_end=0.
  - sync = ~sync_pol (inactive level).
  - The first enabled tick after reset enters ACTIVE.
- Clock edge with enable=0: all outputs hold. line_end clears to 0.
- Clock edge with enable=1 and count > 0:
  - count <= count - DECREMENT, saturating at 0.
  - phase holds.
- Clock edge with enable=1 and count == 0:
  - phase advances ACTIVE→FP→SYNC→BP→ACTIVE (2-bit wrap).
  - count loads (next phase length − 1).
- Phase length L lasts exactly L enabled ticks when DECREMENT=1. A length of 0 is treated as 1, so no phase can be skipped.
- Full cycle length is active_len+fp_len+sync_len+bp_len enabled ticks.
- Outputs are registered and update on the same edge as phase:
  - display_en = (next phase == ACTIVE).
  - sync = (next phase == SYNC) XOR ~sync_pol.
- line_end:
  - Set for exactly one clk on the edge where BP→ACTIVE occurs.
  - Cleared on the following edge, regardless of enable.
- Length inputs are sampled only on the edge that loads them. Changes mid-phase have no effect until the next entry into that phase.
- sync_pol change takes effect on the next enabled edge.
- Reset mid-phase: immediate return to reset state. No partial pulse on line_end.

Optional Feature:
- Macro: PHASE_DOWNCOUNTER_SHADOW_EN.
- Defined:
  - All four lengths are latched into shadow registers on each BP→ACTIVE transition and on reset exit (first enabled tick).
  - Phase loads use the shadow values, so a line/frame always uses one coherent timing set.
- Undefined: no shadow registers; each length is sampled at its own phase entry as described above.

Decomposition:
- Shared include crtc_defs.vh holds:
  - phase encoding localparams PH_ACTIVE=0, PH_FP=1, PH_SYNC=2, PH_BP=3;
  - the "length 0 → 1" clamp rule as a documented constant.
- Sub-module phase_len_sel (combinational 4:1 length mux with zero-clamp) keeps the sequencer readable. It is used by both the shadow and non-shadow builds.

Test Plan:
- Reset then enable held high, active=4, fp=2, sync=3, bp=1, sync_pol=1 → display_en high 4 ticks, low 6; sync high exactly ticks 7–9; line_end pulse after tick 10; repeats with period 10.
- Same lengths, enable toggling every other clk → identical output sequence stretched 2×; line_end is still 1 clk wide.
- sync_len=0 → SYNC lasts 1 tick; fp_len=0 → FP lasts 1 tick; total period = active+1+1+bp.
- Change active_len 4→8 during SYNC, non-shadow build → next ACTIVE lasts 8. Same change during ACTIVE → current ACTIVE is unaffected; SHADOW_EN build applies it only after the next line_end.
- Assert reset_n low mid-SYNC for 1 clk → phase=BP, count=0, sync inactive immediately (async); first enabled tick after release enters ACTIVE with count=active_len−1.
- sync_pol=0 with the same timing → sync low only during SYNC ticks, high elsewhere including during reset.
